// File: rtl/uart_rx_pkg.sv
// Shared encodings for the UART Rx frame checker: parity modes, error-flag bit
// positions and the line-fault state machine states.
package uart_rx_pkg;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    localparam int unsigned ERR_PAR   = 0;
    localparam int unsigned ERR_START = 1;
    localparam int unsigned ERR_STOP  = 2;
    localparam int unsigned ERR_W     = 3;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        DEGRADED = 2'b01,
        FAULT    = 2'b10
    } line_state_e;

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter; a clear coincident with an increment lands on 1.
module uart_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Per-frame start/stop/parity checker with break detection, saturating error
// statistics, sticky status and a consecutive-error line-fault state machine.
module uart_rx_frame_checker
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned CONSEC_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  recieved_flag,
    input  logic [DATA_WIDTH-1:0] raw_data,
    input  logic                  parity_bit,
    input  logic                  start_bit,
    input  logic                  stop_bit,
    input  logic [1:0]            parity_type,
    input  logic                  clr_stats,
    output logic [ERR_W-1:0]      error_flag,
    output logic                  err_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  break_det,
    output logic [ERR_W-1:0]      sticky_status,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  parity_err_cnt,
    output logic [CNT_WIDTH-1:0]  start_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt,
    output logic                  line_fault
);

    logic [ERR_W-1:0]     err_c;
    logic                 par_x_c;
    logic                 break_c;
    logic                 frame_err_c;
    line_state_e          state, state_next, base_state;
    logic [CNT_WIDTH-1:0] consec, consec_next, base_consec;

    assign par_x_c     = (^raw_data) ^ parity_bit;
    assign break_c     = (raw_data == '0) && !stop_bit;
    assign frame_err_c = |err_c;

    // Frame error classification from the sampled frame fields
    always_comb begin
        err_c            = '0;
        err_c[ERR_START] = start_bit;
        err_c[ERR_STOP]  = !stop_bit;
        case (parity_type)
            PAR_ODD:  err_c[ERR_PAR] = !par_x_c;
            PAR_EVEN: err_c[ERR_PAR] = par_x_c;
            default:  err_c[ERR_PAR] = 1'b0;
        endcase
    end

    // Per-frame results, sticky status and one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_flag    <= '0;
            err_valid     <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            break_det     <= 1'b0;
            sticky_status <= '0;
        end else begin
            err_valid  <= recieved_flag;
            data_valid <= recieved_flag && !frame_err_c;
            break_det  <= recieved_flag && break_c;
            if (recieved_flag) begin
                error_flag <= err_c;
                data_out   <= raw_data;
            end
            if (clr_stats) begin
                sticky_status <= recieved_flag ? err_c : '0;
            end else if (recieved_flag) begin
                sticky_status <= sticky_status | err_c;
            end
        end
    end

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk(clk), .rst_n(rst_n), .inc(recieved_flag),
        .clr(clr_stats), .count(frame_cnt)
    );

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_parity_cnt (
        .clk(clk), .rst_n(rst_n), .inc(recieved_flag && err_c[ERR_PAR]),
        .clr(clr_stats), .count(parity_err_cnt)
    );

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_start_cnt (
        .clk(clk), .rst_n(rst_n), .inc(recieved_flag && err_c[ERR_START]),
        .clr(clr_stats), .count(start_err_cnt)
    );

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_stop_cnt (
        .clk(clk), .rst_n(rst_n), .inc(recieved_flag && err_c[ERR_STOP]),
        .clr(clr_stats), .count(stop_err_cnt)
    );

    // Line-fault state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OK;
            consec     <= '0;
            line_fault <= 1'b0;
        end else begin
            state      <= state_next;
            consec     <= consec_next;
            line_fault <= (state_next == FAULT);
        end
    end

    // A clear takes effect first, so a coincident frame is evaluated from OK
    always_comb begin
        base_state  = clr_stats ? OK : state;
        base_consec = clr_stats ? '0 : consec;
        state_next  = base_state;
        consec_next = base_consec;
        if (recieved_flag) begin
            case (base_state)
                OK: begin
                    if (frame_err_c) begin
                        state_next  = DEGRADED;
                        consec_next = CNT_WIDTH'(1);
                    end
                end
                DEGRADED: begin
                    if (frame_err_c) begin
                        consec_next = base_consec + CNT_WIDTH'(1);
                        if (consec_next == CNT_WIDTH'(CONSEC_LIMIT)) begin
                            state_next = FAULT;
                        end
                    end else begin
                        state_next  = OK;
                        consec_next = '0;
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next  = OK;
                    consec_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Randomised and directed bench for uart_rx_frame_checker against a behavioural
// frame model kept in plain integers.
module tb_uart_rx_frame_checker;

    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned LIM   = 4;
    localparam int unsigned CMAX  = (1 << CW) - 1;
    localparam int unsigned VW    = 3 + 3 + DW + 3 + 4 * CW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          recieved_flag = 1'b0;
    logic [DW-1:0] raw_data = '0;
    logic          parity_bit = 1'b0;
    logic          start_bit = 1'b0;
    logic          stop_bit = 1'b1;
    logic [1:0]    parity_type = 2'b00;
    logic          clr_stats = 1'b0;
    logic [2:0]    error_flag;
    logic          err_valid;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          break_det;
    logic [2:0]    sticky_status;
    logic [CW-1:0] frame_cnt, parity_err_cnt, start_err_cnt, stop_err_cnt;
    logic          line_fault;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [2:0]    m_flag, m_sticky;
    logic          m_ev, m_dv, m_brk;
    logic [DW-1:0] m_data;
    int            m_frames, m_par, m_start, m_stop, m_run;
    bit            m_fault;

    uart_rx_frame_checker #(
        .DATA_WIDTH(DW), .CNT_WIDTH(CW), .CONSEC_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .recieved_flag(recieved_flag),
        .raw_data(raw_data), .parity_bit(parity_bit), .start_bit(start_bit),
        .stop_bit(stop_bit), .parity_type(parity_type), .clr_stats(clr_stats),
        .error_flag(error_flag), .err_valid(err_valid), .data_out(data_out),
        .data_valid(data_valid), .break_det(break_det),
        .sticky_status(sticky_status), .frame_cnt(frame_cnt),
        .parity_err_cnt(parity_err_cnt), .start_err_cnt(start_err_cnt),
        .stop_err_cnt(stop_err_cnt), .line_fault(line_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] sat(input int n);
        return (n > int'(CMAX)) ? CW'(CMAX) : CW'(n);
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {error_flag, err_valid, data_valid, break_det, data_out, sticky_status,
                frame_cnt, parity_err_cnt, start_err_cnt, stop_err_cnt, line_fault};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_flag, m_ev, m_dv, m_brk, m_data, m_sticky, sat(m_frames),
                sat(m_par), sat(m_start), sat(m_stop), m_fault};
    endfunction

    // Expected flags from the frame rules: count ones, judge parity by total
    function automatic logic [2:0] frame_flags(input logic [DW-1:0] d, input logic pb,
                                               input logic sb, input logic stb,
                                               input logic [1:0] pt);
        int ones;
        logic [2:0] f;
        ones = $countones(d) + int'(pb);
        f = 3'b000;
        if (pt == 2'b01 && (ones % 2) == 0) f[0] = 1'b1;
        if (pt == 2'b10 && (ones % 2) == 1) f[0] = 1'b1;
        f[1] = (sb != 1'b0);
        f[2] = (stb != 1'b1);
        return f;
    endfunction

    task automatic model_reset();
        m_flag = '0; m_sticky = '0; m_ev = 0; m_dv = 0; m_brk = 0; m_data = '0;
        m_frames = 0; m_par = 0; m_start = 0; m_stop = 0; m_run = 0; m_fault = 0;
    endtask

    task automatic model_step();
        logic [2:0] f;
        if (clr_stats) begin
            m_frames = 0; m_par = 0; m_start = 0; m_stop = 0;
            m_sticky = '0; m_run = 0; m_fault = 0;
        end
        if (recieved_flag) begin
            f = frame_flags(raw_data, parity_bit, start_bit, stop_bit, parity_type);
            m_flag = f;
            m_data = raw_data;
            m_ev   = 1'b1;
            m_dv   = (f == 3'b000);
            m_brk  = (raw_data == '0) && !stop_bit;
            m_frames++;
            m_par   += int'(f[0]);
            m_start += int'(f[1]);
            m_stop  += int'(f[2]);
            m_sticky |= f;
            if (!m_fault) begin
                if (f != 3'b000) begin
                    m_run++;
                    if (m_run >= int'(LIM)) m_fault = 1;
                end else begin
                    m_run = 0;
                end
            end
        end else begin
            m_ev = 0; m_dv = 0; m_brk = 0;
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, settle 1 time unit
    task automatic cyc(input logic fl, input logic [DW-1:0] d, input logic pb,
                       input logic sb, input logic stb, input logic [1:0] pt,
                       input logic clr);
        recieved_flag = fl; raw_data = d; parity_bit = pb; start_bit = sb;
        stop_bit = stb; parity_type = pt; clr_stats = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", obs_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_directed();
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        total++;
        if (error_flag !== 3'b000 || err_valid !== 1'b1 || data_valid !== 1'b1 ||
            data_out !== 8'hA5 || frame_cnt !== 4'd1) begin
            bad++;
            $display("FAIL clean_frame: flag=%b ev=%b dv=%b data=%h cnt=%0d want 000 1 1 a5 1",
                     error_flag, err_valid, data_valid, data_out, frame_cnt);
        end
        cyc(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
        total++;
        if (error_flag !== 3'b011 || data_valid !== 1'b0 || parity_err_cnt !== 4'd1 ||
            start_err_cnt !== 4'd1 || sticky_status !== 3'b011) begin
            bad++;
            $display("FAIL par_start_err: flag=%b dv=%b pc=%0d sc=%0d sticky=%b want 011 0 1 1 011",
                     error_flag, data_valid, parity_err_cnt, start_err_cnt, sticky_status);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, (i == 0) ? 2'b00 : 2'b11, 1'b0);
            total++;
            if (error_flag !== 3'b000 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL parity_off_%0d: flag=%b vec=%h want 000 %h",
                         i, error_flag, obs_vec(), exp_vec());
            end
        end
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        total++;
        if (break_det !== 1'b1 || error_flag !== 3'b100 || stop_err_cnt !== 4'd1) begin
            bad++;
            $display("FAIL break: brk=%b flag=%b stopc=%0d want 1 100 1",
                     break_det, error_flag, stop_err_cnt);
        end
        idle();
        total++;
        if (obs_vec() !== exp_vec() || break_det !== 1'b0 || err_valid !== 1'b0) begin
            bad++;
            $display("FAIL pulses_drop: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_line_fault();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
            total++;
            if (line_fault !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fault_early_%0d: lf=%b vec=%h want 0 %h",
                         i, line_fault, obs_vec(), exp_vec());
            end
        end
        cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
        total++;
        if (line_fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_set: lf=%b want 1", line_fault);
        end
        cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        total++;
        if (line_fault !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL fault_hold: lf=%b want 1", line_fault);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        total++;
        if (line_fault !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL recover_ok: lf=%b vec=%h want 0 %h", line_fault, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic fl, clr, sb, stb, pb;
        logic [DW-1:0] d;
        logic [1:0] pt;
        for (int i = 0; i < 200; i++) begin
            fl  = ($urandom_range(3) != 0);
            clr = ($urandom_range(15) == 0);
            sb  = ($urandom_range(5) == 0);
            stb = ($urandom_range(5) != 0);
            pb  = 1'($urandom);
            pt  = 2'($urandom);
            d   = ($urandom_range(7) == 0) ? '0 : DW'($urandom);
            cyc(fl, d, pb, sb, stb, pt, clr);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, DW'($urandom) | DW'(1), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL sat_step_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (stop_err_cnt !== 4'd15 || frame_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_value: stopc=%0d frames=%0d want 15 15", stop_err_cnt, frame_cnt);
        end
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        total++;
        if (stop_err_cnt !== 4'd1 || sticky_status !== 3'b100 || line_fault !== 1'b0 ||
            frame_cnt !== 4'd1) begin
            bad++;
            $display("FAIL clr_with_frame: stopc=%0d sticky=%b lf=%b frames=%0d want 1 100 0 1",
                     stop_err_cnt, sticky_status, line_fault, frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 2; i++) cyc(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        recieved_flag = 1'b1; raw_data = 8'hFF; start_bit = 1'b1; stop_bit = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", obs_vec());
        end
        @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL reset_discard: got %h want 0", obs_vec());
        end
        @(negedge clk);
        recieved_flag = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cyc(1'b1, 8'h3E, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL after_reset: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_directed();
        test_line_fault();
        test_random();
        test_saturation();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
